// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic WE_RE_READ  = 1'b0;
  localparam logic WE_RE_WRITE = 1'b1;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// rtl/mem_arb_if.sv - core-side request port and memory-side bus interfaces
interface mem_arb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              request;
  logic              we_re;
  logic [3:0]        mask;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic [DATA_W-1:0] data_out;

  modport master (output request, we_re, mask, address, data_in, input valid, data_out);
  modport slave  (input request, we_re, mask, address, data_in, output valid, data_out);
endinterface

interface mem_bus_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              request;
  logic              we_re;
  logic [3:0]        mask;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic [DATA_W-1:0] data_out;

  modport master (output request, we_re, mask, load, address, data_in, input valid, data_out);
  modport slave  (input request, we_re, mask, load, address, data_in, output valid, data_out);
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// rtl/mem_arb_starve_cnt.sv - saturating count of data grants taken while fetch waits
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] count_q;

  assign at_limit_o = (count_q == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && !at_limit_o) begin
      count_q <= count_q + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fixed-priority fetch/data arbiter for one single-ported memory
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  i_port,
  mem_arb_if.slave  d_port,
  input  logic      d_load,
  mem_bus_if.master mem
);

  arb_state_e        state_q;
  logic              req_q;
  logic              we_re_q;
  logic [3:0]        mask_q;
  logic              load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic at_limit;
  logic pick_d;
  logic pick_i;

  // Data wins unless fetch has waited out STARVE_LIMIT data grants.
  assign pick_d = (state_q == IDLE) && d_port.request && !(i_port.request && at_limit);
  assign pick_i = (state_q == IDLE) && !pick_d && i_port.request;

  mem_arb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (pick_d && i_port.request),
    .clr_i     (pick_i || (pick_d && !i_port.request)),
    .at_limit_o(at_limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_re_q   <= WE_RE_READ;
      mask_q    <= '0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q <= GNT_D;
            req_q   <= 1'b1;
            we_re_q <= d_port.we_re;
            mask_q  <= d_port.mask;
            load_q  <= d_load;
            addr_q  <= d_port.address;
            wdata_q <= d_port.data_in;
          end else if (pick_i) begin
            state_q <= GNT_I;
            req_q   <= 1'b1;
            we_re_q <= i_port.we_re;
            mask_q  <= i_port.mask;
            load_q  <= 1'b0;
            addr_q  <= i_port.address;
            wdata_q <= i_port.data_in;
          end
        end
        GNT_I, GNT_D: begin
          if (mem.valid) begin
            state_q <= RESP;
            req_q   <= 1'b0;
            if (state_q == GNT_I) begin
              i_valid_q <= 1'b1;
              i_rdata_q <= mem.data_out;
            end else begin
              d_valid_q <= 1'b1;
              d_rdata_q <= mem.data_out;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          i_valid_q <= 1'b0;
          d_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.request    = req_q;
  assign mem.we_re      = we_re_q;
  assign mem.mask       = mask_q;
  assign mem.load       = load_q;
  assign mem.address    = addr_q;
  assign mem.data_in    = wdata_q;
  assign i_port.valid    = i_valid_q;
  assign i_port.data_out = i_rdata_q;
  assign d_port.valid    = d_valid_q;
  assign d_port.data_out = d_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for the unified memory arbiter
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic d_load;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(8), .DATA_W(32)) i_if ();
  mem_arb_if #(.ADDR_W(8), .DATA_W(32)) d_if ();
  mem_bus_if #(.ADDR_W(8), .DATA_W(32)) mem_if ();

  unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_port(i_if),
    .d_port(d_if),
    .d_load(d_load),
    .mem   (mem_if)
  );

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [3:0]  mask;
    logic        load;
    logic [31:0] wdata;
    logic [3:0]  starve;
  } gnt_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } resp_t;

  gnt_t  gnt_q[$];
  resp_t resp_q[$];
  gnt_t  mon_g;
  resp_t mon_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory model: returns mem_rdata mem_delay cycles after the first grant cycle.
  int          mem_delay = 1;
  logic [31:0] mem_rdata = 32'h0;
  logic        force_valid = 1'b0;
  int          mcnt = 0;
  always @(negedge clk) begin
    if (force_valid) begin
      mem_if.valid    = 1'b1;
      mem_if.data_out = 32'hBAD0BAD0;
    end else if (mem_if.request === 1'b1) begin
      mcnt = mcnt + 1;
      mem_if.valid    = (mcnt == mem_delay + 1);
      mem_if.data_out = (mcnt == mem_delay + 1) ? mem_rdata : 32'h0;
    end else begin
      mcnt = 0;
      mem_if.valid    = 1'b0;
      mem_if.data_out = 32'h0;
    end
  end

  logic prev_req = 1'b0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  always @(posedge clk) begin
    #1;
    if (mem_if.request === 1'b1 && !prev_req) begin
      rise_cyc = cyc;
      if (gnt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant actual=addr_%h required=no_grant", mem_if.address);
      end else begin
        mon_g = gnt_q.pop_front();
        chk("gnt_addr", mem_if.address, mon_g.addr);
        chk("gnt_we_re", mem_if.we_re, mon_g.we);
        chk("gnt_mask", mem_if.mask, mon_g.mask);
        chk("gnt_load", mem_if.load, mon_g.load);
        chk("gnt_wdata", mem_if.data_in, mon_g.wdata);
        chk("gnt_starve", dut.u_starve.count_q, mon_g.starve);
      end
    end
    if (mem_if.request !== 1'b1 && prev_req) fall_cyc = cyc;
    prev_req = (mem_if.request === 1'b1);
  end

  always @(posedge clk) begin
    #1;
    if (i_if.valid === 1'b1 && d_if.valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL both_valid actual=11 required=one_hot");
    end else if (i_if.valid === 1'b1 || d_if.valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=d_valid_%b required=none", d_if.valid);
      end else begin
        mon_r = resp_q.pop_front();
        chk("resp_port", d_if.valid, mon_r.port);
        chk("resp_data", (d_if.valid === 1'b1) ? d_if.data_out : i_if.data_out, mon_r.data);
      end
    end
  end

  task automatic wait_valid(input logic port, input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (((port == PORT_D) ? d_if.valid : i_if.valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout_port%0d actual=no_valid required=valid", port);
    end
  endtask

  task automatic push_gnt(input logic [7:0] a, input logic we, input logic [3:0] m,
                          input logic ld, input logic [31:0] wd, input logic [3:0] st);
    gnt_t g;
    g.addr = a; g.we = we; g.mask = m; g.load = ld; g.wdata = wd; g.starve = st;
    gnt_q.push_back(g);
  endtask

  task automatic push_resp(input logic p, input logic [31:0] dat);
    resp_t r;
    r.port = p; r.data = dat;
    resp_q.push_back(r);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_request"}, mem_if.request, 1'b0);
    chk({tag, "_mem_we_re"}, mem_if.we_re, 1'b0);
    chk({tag, "_mem_mask"}, mem_if.mask, 4'h0);
    chk({tag, "_mem_load"}, mem_if.load, 1'b0);
    chk({tag, "_mem_address"}, mem_if.address, 8'h00);
    chk({tag, "_mem_data_in"}, mem_if.data_in, 32'h0);
    chk({tag, "_i_valid"}, i_if.valid, 1'b0);
    chk({tag, "_d_valid"}, d_if.valid, 1'b0);
    chk({tag, "_i_data_out"}, i_if.data_out, 32'h0);
    chk({tag, "_d_data_out"}, d_if.data_out, 32'h0);
    chk({tag, "_state"}, dut.state_q, 2'd0);
    chk({tag, "_starve"}, dut.u_starve.count_q, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int pulses;
    int reqs;
    int f;
    rst = 1'b1;
    d_load = 1'b0;
    i_if.request = 1'b0; i_if.we_re = 1'b0; i_if.mask = 4'h0; i_if.address = 8'h0; i_if.data_in = 32'h0;
    d_if.request = 1'b0; d_if.we_re = 1'b0; d_if.mask = 4'h0; d_if.address = 8'h0; d_if.data_in = 32'h0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: fetch only, mem_valid one cycle after grant
    mem_delay = 1;
    mem_rdata = 32'h00500093;
    i_if.address = 8'h04; i_if.we_re = WE_RE_READ; i_if.mask = 4'hF;
    push_gnt(8'h04, 1'b0, 4'hF, 1'b0, 32'h0, 4'd0);
    push_resp(PORT_I, 32'h00500093);
    i_if.request = 1'b1;
    @(posedge clk); #1;
    chk("t1_mem_req_c0", mem_if.request, 1'b1);
    @(posedge clk); #1;
    chk("t1_i_valid_c2", i_if.valid, 1'b0);
    @(posedge clk); #1;
    chk("t1_i_valid_c3", i_if.valid, 1'b1);
    chk("t1_i_data", i_if.data_out, 32'h00500093);
    @(negedge clk);
    i_if.request = 1'b0;
    repeat (2) @(negedge clk);

    // 2: collision, D write wins, I follows after RESP+IDLE
    mem_rdata = 32'h11112222;
    d_if.address = 8'h10; d_if.we_re = WE_RE_WRITE; d_if.data_in = 32'hDEADBEEF; d_if.mask = 4'hF;
    push_gnt(8'h10, 1'b1, 4'hF, 1'b0, 32'hDEADBEEF, 4'd1);
    push_gnt(8'h04, 1'b0, 4'hF, 1'b0, 32'h0, 4'd0);
    push_resp(PORT_D, 32'h11112222);
    push_resp(PORT_I, 32'h11112222);
    d_if.request = 1'b1;
    i_if.request = 1'b1;
    wait_valid(PORT_D, 20);
    f = fall_cyc;
    d_if.request = 1'b0;
    wait_valid(PORT_I, 20);
    i_if.request = 1'b0;
    chk("t2_gap", rise_cyc - f, 2);
    repeat (2) @(negedge clk);

    // 3: starvation, order D,D,D,D,I,D then the trailing I
    mem_rdata = 32'hCAFE0003;
    d_if.address = 8'h40; d_if.we_re = WE_RE_READ; d_if.data_in = 32'h0; d_if.mask = 4'hF;
    i_if.address = 8'h08;
    for (int k = 1; k <= 4; k++) begin
      push_gnt(8'h40, 1'b0, 4'hF, 1'b0, 32'h0, 4'(k));
      push_resp(PORT_D, 32'hCAFE0003);
    end
    push_gnt(8'h08, 1'b0, 4'hF, 1'b0, 32'h0, 4'd0);
    push_resp(PORT_I, 32'hCAFE0003);
    push_gnt(8'h40, 1'b0, 4'hF, 1'b0, 32'h0, 4'd1);
    push_resp(PORT_D, 32'hCAFE0003);
    push_gnt(8'h08, 1'b0, 4'hF, 1'b0, 32'h0, 4'd0);
    push_resp(PORT_I, 32'hCAFE0003);
    d_if.request = 1'b1;
    i_if.request = 1'b1;
    for (int k = 0; k < 5; k++) wait_valid(PORT_D, 30);
    d_if.request = 1'b0;
    wait_valid(PORT_I, 30);
    i_if.request = 1'b0;
    repeat (2) @(negedge clk);

    // 4: slow memory, mem_valid 7 cycles after grant
    mem_delay = 7;
    mem_rdata = 32'h77770007;
    d_if.address = 8'h50;
    push_gnt(8'h50, 1'b0, 4'hF, 1'b0, 32'h0, 4'd0);
    push_resp(PORT_D, 32'h77770007);
    d_if.request = 1'b1;
    hi = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (mem_if.request === 1'b1) hi++;
      if (d_if.valid === 1'b1) break;
    end
    chk("t4_req_cycles", hi, 8);
    d_if.request = 1'b0;
    pulses = 1;
    reqs = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (d_if.valid === 1'b1) pulses++;
      if (mem_if.request === 1'b1) reqs++;
    end
    chk("t4_d_valid_pulses", pulses, 1);
    chk("t4_no_regrant", reqs, 0);

    // 5: reset mid-grant abandons the access
    mem_delay = 10;
    d_if.address = 8'h60; d_if.we_re = WE_RE_WRITE; d_if.data_in = 32'h12345678; d_if.mask = 4'h3;
    push_gnt(8'h60, 1'b1, 4'h3, 1'b0, 32'h12345678, 4'd0);
    d_if.request = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_in_gnt_d", dut.state_q, 2'd2);
    rst = 1'b1;
    d_if.request = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("t5");
    @(negedge clk);
    rst = 1'b0;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (d_if.valid === 1'b1) pulses++;
    end
    chk("t5_no_d_valid", pulses, 0);

    // 6: field change mid-grant does not reach the memory
    mem_delay = 4;
    mem_rdata = 32'h66660006;
    d_load = 1'b1;
    d_if.address = 8'h20; d_if.we_re = WE_RE_READ; d_if.data_in = 32'h0; d_if.mask = 4'h1;
    push_gnt(8'h20, 1'b0, 4'h1, 1'b1, 32'h0, 4'd0);
    push_resp(PORT_D, 32'h66660006);
    d_if.request = 1'b1;
    repeat (2) @(negedge clk);
    d_if.address = 8'h30;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("t6_mem_address", mem_if.address, 8'h20);
      if (d_if.valid === 1'b1) break;
    end
    d_if.request = 1'b0;
    d_load = 1'b0;
    repeat (4) @(negedge clk);

    chk("end_gnt_q_empty", gnt_q.size(), 0);
    chk("end_resp_q_empty", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
